piso_bit_serializer: RTL

//  Parallel-in/serial-out stage feeding the serial sequence detectors (e.g. the 1011 Moore detector).

---
 rtl/piso_bit_serializer.sv | 79 +++++++
 1 files changed

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: valid/ready parallel word in, one bit per clk out on a registered serial line.
module piso_bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP        = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             signal,
    output logic             signal_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [GW-1:0] gap_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    cnt_t             bit_cnt_q;
    gap_t             gap_cnt_q;
    logic             signal_q, signal_valid_q, done_q;
    logic             last, hs;
    assign last         = (state_q == ST_SHIFT) && (bit_cnt_q == cnt_t'(WIDTH - 1));
    assign din_ready    = (state_q == ST_IDLE) || ((GAP == 0) && last);
    assign hs           = din_valid && din_ready;
    assign signal       = signal_q;
    assign signal_valid = signal_valid_q;
    assign done         = done_q;
    assign busy         = state_q != ST_IDLE;
    // sh_q holds the bits not yet driven; signal_q already carries the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sh_q           <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            signal_q       <= IDLE_LEVEL;
            signal_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hs) begin
                state_q        <= ST_SHIFT;
                sh_q           <= MSB_FIRST ? din << 1 : din >> 1;
                signal_q       <= MSB_FIRST ? din[WIDTH-1] : din[0];
                signal_valid_q <= 1'b1;
                bit_cnt_q      <= '0;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (last) begin
                            state_q        <= (GAP == 0) ? ST_IDLE : ST_GAP;
                            gap_cnt_q      <= '0;
                            signal_q       <= IDLE_LEVEL;
                            signal_valid_q <= 1'b0;
                        end else begin
                            signal_q  <= MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
                            sh_q      <= MSB_FIRST ? sh_q << 1 : sh_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            done_q    <= bit_cnt_q == cnt_t'(WIDTH - 2);
                        end
                    end
                    ST_GAP: begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                        if (gap_cnt_q == gap_t'(GAP - 1))
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
